// File: rtl/async_down_counter.sv
// Ripple (asynchronous) binary down counter.
// Stage 0 toggles on every rising clk edge. Every later stage toggles on the
// rising edge of the stage below it. Because each stage rises as it leaves
// 0 (the point where a down count borrows), the chain counts down.
// Outputs ripple and are not synchronous to clk. Consumers must sample count
// only after the ripple has settled, for example on the falling clk edge.
// rst is an asynchronous, active-low clear that overrides every stage.
module async_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    // Per-stage clock: clk for stage 0, the previous stage's output otherwise.
    logic [WIDTH-1:0] stage_clk;
    // Collected stage outputs.
    logic [WIDTH-1:0] q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            logic bit_d;
            logic bit_q;

            if (i == 0) begin : g_first
                assign stage_clk[i] = clk;
            end else begin : g_chain
                assign stage_clk[i] = q[i-1];
            end

            // Toggle flip-flop input: next state is always the inverse.
            always_comb bit_d = ~bit_q;

            // Stage flop. The asynchronous clear wins over any clock edge.
            // A clear only drives bits 1->0, which is a falling edge, so it
            // can never clock a downstream stage.
            always_ff @(posedge stage_clk[i] or negedge rst) begin
                if (!rst) bit_q <= 1'b0;
                else      bit_q <= bit_d;
            end

            assign q[i] = bit_q;
        end
    endgenerate

    assign count = q;

endmodule

// File: tb/tb_async_down_counter.sv
// Testbench for async_down_counter, using WIDTH=4 and WIDTH=8 instances on a shared clk.
// A modulo-arithmetic model is compared with both instances on every falling clk edge.
// Directed steps pin the model with hand-computed literal values.
module tb_async_down_counter;

    logic       clk;
    logic       rst4;
    logic       rst8;
    logic [3:0] count4;
    logic [7:0] count8;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the counter value is an integer modulo 2^WIDTH.
    int m4 = 0;
    int m8 = 0;

    async_down_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .count(count4));
    async_down_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .count(count8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst4) begin
        if (!rst4) m4 <= 0;
        else       m4 <= (m4 + 16 - 1) % 16;
    end

    always @(posedge clk or negedge rst8) begin
        if (!rst8) m8 <= 0;
        else       m8 <= (m8 + 256 - 1) % 256;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if ($isunknown(count4) || int'(count4) != m4) begin
            errors++;
            $display("FAIL model4: got %0h, expected %0h at %0t", count4, m4, $time);
        end
        checks++;
        if ($isunknown(count8) || int'(count8) != m8) begin
            errors++;
            $display("FAIL model8: got %0h, expected %0h at %0t", count8, m8, $time);
        end
    end

    initial begin
        logic [3:0] first5 [5];
        first5 = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB};

        rst4 = 1'b0;
        rst8 = 1'b0;

        // Power-up: reset held while clk runs, so no edges are counted.
        repeat (2) begin
            @(negedge clk);
            check("powerup4", count4, 0);
            check("powerup8", count8, 0);
        end

        // Release away from any rising edge. Release alone changes nothing.
        rst4 = 1'b1;
        rst8 = 1'b1;
        #1;
        check("release_no_change", count4, 0);

        // First five edges after release.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("first_edges", count4, first5[k]);
            if (k == 0) check("w8_first_edge", count8, 8'hFF);
        end

        // Wrap: edge 16 returns to 0, edge 17 gives all-ones.
        repeat (11) @(negedge clk);
        check("wrap_zero", count4, 4'h0);
        @(negedge clk);
        check("wrap_ones", count4, 4'hF);

        // Advance to 1010 (five more edges: F->A).
        repeat (5) @(negedge clk);
        check("reach_1010", count4, 4'hA);

        // Asynchronous reset mid-count while clk is high.
        @(posedge clk);
        #2;
        rst4 = 1'b0;
        #1;
        check("async_clear", count4, 4'h0);
        #4;
        rst4 = 1'b1;
        #1;
        check("after_release", count4, 4'h0);
        @(negedge clk);
        check("resume_ones", count4, 4'hF);
        @(negedge clk);
        check("resume_e", count4, 4'hE);

        // Reset held across three rising edges.
        rst4 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("held_reset", count4, 4'h0);
        end
        rst4 = 1'b1;
        @(negedge clk);
        check("held_release_ones", count4, 4'hF);

        // WIDTH=8: the full period from reset.
        rst8 = 1'b0;
        @(negedge clk);
        check("w8_reset", count8, 8'h00);
        rst8 = 1'b1;
        @(negedge clk);
        check("w8_edge1", count8, 8'hFF);
        repeat (127) @(negedge clk);
        check("w8_edge128", count8, 8'h80);
        repeat (128) @(negedge clk);
        check("w8_edge256", count8, 8'h00);
        @(negedge clk);
        check("w8_edge257", count8, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
